// File: rtl/fp_serial_sign_mag_if.sv
// Interface for the serial sign/magnitude front end: the serial input stream,
// the output word handshake and the status outputs.
interface fp_serial_sign_mag_if #(
  parameter int unsigned WIDTH = 12
);
  logic             s_valid;
  logic             s_bit;
  logic             s_first;
  logic             m_valid;
  logic             m_ready;
  logic             m_sign;
  logic [WIDTH-2:0] m_mag;
  logic             m_sat;
  logic             frame_err;
  logic [7:0]       drop_cnt;

  modport slave (
    input  s_valid, s_bit, s_first, m_ready,
    output m_valid, m_sign, m_mag, m_sat, frame_err, drop_cnt
  );

  modport master (
    output s_valid, s_bit, s_first, m_ready,
    input  m_valid, m_sign, m_mag, m_sat, frame_err, drop_cnt
  );
endinterface

// File: rtl/fp_serial_sign_mag.sv
// Deserialises MSB-first two's-complement samples and converts each one to
// sign/magnitude (clamping the most-negative value), queued in a FWFT FIFO.
module fp_serial_sign_mag #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 2
) (
  input logic                clk,
  input logic                rst,
  fp_serial_sign_mag_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RECV} state_t;

  typedef struct packed {
    logic             sign;
    logic [WIDTH-2:0] mag;
    logic             sat;
  } entry_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-2:0] sh_q;
  logic             frame_err_q;

  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] neg_d;
  logic             done_d;
  entry_t           entry_d;

  entry_t           mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [7:0]       drop_cnt_q;

  logic             empty;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;
  entry_t           head;

  always_comb begin
    word_d        = {sh_q, bus.s_bit};
    neg_d         = -word_d;
    done_d        = (state_q == RECV) && bus.s_valid && !bus.s_first
                    && (cnt_q == CW'(WIDTH - 1));
    entry_d.sign  = word_d[WIDTH-1];
    // -2^(WIDTH-1) has no positive counterpart; its negation wraps back to itself.
    entry_d.sat   = word_d[WIDTH-1] && (word_d[WIDTH-2:0] == '0);
    if (entry_d.sat) begin
      entry_d.mag = '1;
    end else if (entry_d.sign) begin
      entry_d.mag = neg_d[WIDTH-2:0];
    end else begin
      entry_d.mag = word_d[WIDTH-2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (bus.s_valid) begin
        if (bus.s_first) begin
          frame_err_q <= (state_q == RECV);
          sh_q        <= (WIDTH-1)'(bus.s_bit);
          cnt_q       <= CW'(1);
          state_q     <= RECV;
        end else if (state_q == IDLE) begin
          frame_err_q <= 1'b1;
        end else if (done_d) begin
          cnt_q       <= '0;
          state_q     <= IDLE;
        end else begin
          sh_q        <= word_d[WIDTH-2:0];
          cnt_q       <= cnt_q + CW'(1);
        end
      end
    end
  end

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop     = !empty && bus.m_ready;
    push_ok = done_d && (!full || pop);
    drop    = done_d && full && !pop;
    head    = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pop) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
      if (push_ok) begin
        wptr_q <= wptr_q + (AW+1)'(1);
      end
      if (drop && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= entry_d;
    end
  end

  assign bus.m_valid   = !empty;
  assign bus.m_sign    = !empty && head.sign;
  assign bus.m_mag     = empty ? '0 : head.mag;
  assign bus.m_sat     = !empty && head.sat;
  assign bus.frame_err = frame_err_q;
  assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_fp_serial_sign_mag.sv
// Bench for fp_serial_sign_mag: directed scenarios then random traffic, checked
// every cycle against a queue-based word-level model.
module tb_fp_serial_sign_mag;
  localparam int W = 12;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_serial_sign_mag_if #(.WIDTH(W)) bus ();

  fp_serial_sign_mag #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit sign;
    int mag;
    bit sat;
  } word_t;

  int    checks = 0;
  int    errors = 0;
  word_t q[$];
  bit    in_frame;
  int    nbits;
  int    acc;
  bit    exp_ferr;
  int    exp_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic word_t convert(input int raw);
    word_t w;
    int    sv;
    sv     = (raw >= (1 << (W - 1))) ? raw - (1 << W) : raw;
    w.sign = (sv < 0);
    w.mag  = (sv < 0) ? -sv : sv;
    w.sat  = (w.mag == (1 << (W - 1)));
    if (w.sat) w.mag = (1 << (W - 1)) - 1;
    return w;
  endfunction

  task automatic model_edge(input bit r, input bit v, input bit b, input bit f, input bit rd);
    bit    done;
    word_t w;
    if (r) begin
      q.delete();
      in_frame = 0; nbits = 0; acc = 0; exp_ferr = 0; exp_drop = 0;
      return;
    end
    done     = 0;
    exp_ferr = 0;
    if (v) begin
      if (f) begin
        if (in_frame) exp_ferr = 1;
        in_frame = 1; nbits = 1; acc = int'(b);
      end else if (!in_frame) begin
        exp_ferr = 1;
      end else begin
        acc   = acc * 2 + int'(b);
        nbits = nbits + 1;
        if (nbits == W) begin
          done     = 1;
          in_frame = 0;
        end
      end
    end
    if (rd && q.size() > 0) void'(q.pop_front());
    if (done) begin
      w = convert(acc);
      if (q.size() < D) q.push_back(w);
      else if (exp_drop < 255) exp_drop++;
    end
  endtask

  task automatic check_outputs();
    if (q.size() > 0) begin
      chk("m_valid", 32'(bus.m_valid), 1);
      chk("m_sign", 32'(bus.m_sign), 32'(q[0].sign));
      chk("m_mag", 32'(bus.m_mag), q[0].mag);
      chk("m_sat", 32'(bus.m_sat), 32'(q[0].sat));
    end else begin
      chk("m_valid", 32'(bus.m_valid), 0);
      chk("m_sign_empty", 32'(bus.m_sign), 0);
      chk("m_mag_empty", 32'(bus.m_mag), 0);
      chk("m_sat_empty", 32'(bus.m_sat), 0);
    end
    chk("frame_err", 32'(bus.frame_err), 32'(exp_ferr));
    chk("drop_cnt", 32'(bus.drop_cnt), exp_drop);
  endtask

  task automatic tick(input bit r, input bit v, input bit b, input bit f, input bit rd);
    rst         = r;
    bus.s_valid = v;
    bus.s_bit   = b;
    bus.s_first = f;
    bus.m_ready = rd;
    @(posedge clk);
    model_edge(r, v, b, f, rd);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_bits(input int word, input int n, input bit rd);
    for (int i = W - 1; i > W - 1 - n; i--) tick(0, 1, word[i], i == W - 1, rd);
  endtask

  task automatic send_frame(input int word, input bit rd_body, input bit rd_last);
    for (int i = W - 1; i >= 0; i--) tick(0, 1, word[i], i == W - 1, (i == 0) ? rd_last : rd_body);
  endtask

  initial begin
    bus.s_valid = 0; bus.s_bit = 0; bus.s_first = 0; bus.m_ready = 0;
    @(negedge clk);
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);

    // Basic positive word, one-cycle latency.
    send_frame(12'h1A6, 1, 0);
    chk("t1_mag", 32'(bus.m_mag), 422);
    tick(0, 0, 0, 0, 1);

    // Negative and most-negative words.
    send_frame(12'hFF9, 1, 1);
    chk("t2_neg_mag", 32'(bus.m_mag), 7);
    tick(0, 0, 0, 0, 1);
    send_frame(12'h800, 1, 0);
    chk("t2_sat", 32'(bus.m_sat), 1);
    chk("t2_sat_mag", 32'(bus.m_mag), 2047);
    tick(0, 0, 0, 0, 1);

    // Stray bit while idle, then an aborted frame.
    tick(0, 1, 1, 0, 1);
    tick(0, 0, 0, 0, 1);
    send_bits(12'hABC, 5, 1);
    send_frame(12'h007, 1, 0);
    chk("t3_mag", 32'(bus.m_mag), 7);
    tick(0, 0, 0, 0, 1);

    // Backpressure: third word dropped, then ordered drain.
    send_frame(1, 0, 0);
    send_frame(2, 0, 0);
    send_frame(3, 0, 0);
    chk("t4_drop", 32'(bus.drop_cnt), 1);
    chk("t4_head", 32'(bus.m_mag), 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 1);

    // Full FIFO with a pop on the final bit: accepted, no drop.
    send_frame(10, 0, 0);
    send_frame(11, 0, 0);
    send_frame(12, 0, 1);
    chk("t5_drop", 32'(bus.drop_cnt), 1);
    chk("t5_head", 32'(bus.m_mag), 11);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 1);

    // Reset mid-frame.
    send_bits(12'hFFF, 6, 1);
    tick(1, 0, 0, 0, 1);
    send_frame(12'h0FF, 1, 0);
    chk("t6_mag", 32'(bus.m_mag), 255);
    chk("t6_drop", 32'(bus.drop_cnt), 0);
    tick(0, 0, 0, 0, 1);

    // drop_cnt saturation.
    for (int i = 0; i < 258; i++) send_frame($urandom_range(0, 4095), 0, 0);
    chk("t7_drop_sat", 32'(bus.drop_cnt), 255);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit v, f;
      v = ($urandom_range(0, 3) != 0);
      f = v && ($urandom_range(0, 15) == 0);
      tick($urandom_range(0, 499) == 0, v, 1'($urandom), f, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
